agg: RTL and testbench

AGG -- requirements
Module: agg

---
 rtl/agg_pkg.sv | 13 +
 rtl/agg_sat_add.sv | 17 +
 rtl/agg.sv | 59 +++++
 tb/tb_agg.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/agg_pkg.sv
// Shared defaults and helpers for the windowed saturating aggregator.
package agg_pkg;

  localparam int unsigned AGG_WIDTH_DEF  = 12;
  localparam int unsigned AGG_LEN_DEF    = 4;
  localparam int unsigned ACT_THRESH_DEF = 2048;

  // Window counter width: ceil(log2(len + 1)).
  function automatic int unsigned cnt_width(input int unsigned len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/agg_sat_add.sv
// Combinational unsigned adder that clamps to all-ones instead of wrapping.
module agg_sat_add #(
  parameter int unsigned width = 12
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  output logic [width-1:0] sum
);

  logic [width:0] w_full;

  always_comb begin
    w_full = {1'b0, a} + {1'b0, b};
    sum    = w_full[width] ? {width{1'b1}} : w_full[width-1:0];
  end

endmodule

// File: rtl/agg.sv
// Sums agg_len consecutive samples with saturation and publishes the window sum
// plus a threshold flag on the edge that captures the window's last sample.
module agg
  import agg_pkg::*;
#(
  parameter int unsigned agg_width  = AGG_WIDTH_DEF,
  parameter int unsigned agg_len    = AGG_LEN_DEF,
  parameter int unsigned act_thresh = ACT_THRESH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [agg_width-1:0] agg_in,
  output logic [agg_width-1:0] agg_out2alu,
  output logic                 agg_out_acted
);

  localparam int unsigned CntW = cnt_width(agg_len);
  localparam logic [agg_width-1:0] Thresh  = agg_width'(act_thresh);
  localparam logic [CntW-1:0]      LastCnt = CntW'(agg_len - 1);

  logic [agg_width-1:0] r_acc;
  logic [CntW-1:0]      r_cnt;
  logic [agg_width-1:0] r_out;
  logic                 r_act;
  logic [agg_width-1:0] w_sum;
  logic                 w_last;

  agg_sat_add #(
    .width (agg_width)
  ) u_sat_add (
    .a   (r_acc),
    .b   (agg_in),
    .sum (w_sum)
  );

  assign w_last = (r_cnt == LastCnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_out <= '0;
      r_act <= 1'b0;
    end else if (w_last) begin
      // Window closes: publish and restart with no idle cycle.
      r_acc <= '0;
      r_cnt <= '0;
      r_out <= w_sum;
      r_act <= (w_sum >= Thresh);
    end else begin
      r_acc <= w_sum;
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  assign agg_out2alu   = r_out;
  assign agg_out_acted = r_act;

endmodule

// File: tb/tb_agg.sv
// Directed and randomised checks of agg at agg_len = 4 and agg_len = 1.
module tb_agg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] agg_in = 12'd0;
  logic [11:0] out4;
  logic        act4;
  logic [11:0] out1;
  logic        act1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  agg #(
    .agg_width  (12),
    .agg_len    (4),
    .act_thresh (2048)
  ) u_dut4 (
    .clk           (clk),
    .rst           (rst),
    .agg_in        (agg_in),
    .agg_out2alu   (out4),
    .agg_out_acted (act4)
  );

  agg #(
    .agg_width  (12),
    .agg_len    (1),
    .act_thresh (2048)
  ) u_dut1 (
    .clk           (clk),
    .rst           (rst),
    .agg_in        (agg_in),
    .agg_out2alu   (out1),
    .agg_out_acted (act1)
  );

  typedef struct {
    logic [3:0][11:0] s;
    logic [11:0]      sum;
    logic             act;
  } vec_t;

  vec_t vecs [11];

  function automatic vec_t mk(input int a, input int b, input int c, input int d,
                              input int sum, input bit act);
    vec_t v;
    v.s[0] = 12'(a);
    v.s[1] = 12'(b);
    v.s[2] = 12'(c);
    v.s[3] = 12'(d);
    v.sum  = 12'(sum);
    v.act  = act;
    return v;
  endfunction

  function automatic int sat12(input int a, input int b);
    return (a + b > 4095) ? 4095 : a + b;
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive one sample and let the edge capture it; returns at edge + 1.
  task automatic apply(input int v);
    agg_in = 12'(v);
    @(posedge clk);
    #1;
  endtask

  int m_acc, m_cnt, m_out, m_act, v, s;

  initial begin
    vecs[0]  = mk(1, 3, 2, 4, 10, 0);
    vecs[1]  = mk(1, 3, 2, 2042, 2048, 1);
    vecs[2]  = mk(1, 3, 2, 2041, 2047, 0);
    vecs[3]  = mk(1, 3, 1024, 4095, 4095, 1);
    vecs[4]  = mk(0, 0, 0, 5, 5, 0);
    vecs[5]  = mk(4095, 4095, 4095, 4095, 4095, 1);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(4095, 1, 0, 0, 4095, 1);
    vecs[8]  = mk(2047, 0, 0, 0, 2047, 0);
    vecs[9]  = mk(2048, 0, 0, 0, 2048, 1);
    vecs[10] = mk(1000, 1000, 1000, 1000, 4000, 1);

    // Reset held across edges with a live input.
    #1;
    rst    = 1'b1;
    agg_in = 12'd100;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out4", out4, 0);
    check("rst_act4", act4, 0);
    check("rst_out1", out1, 0);
    check("rst_act1", act1, 0);
    rst = 1'b0;

    // Table windows; outputs must hold the previous result until the 4th sample.
    m_out = 0;
    m_act = 0;
    for (int i = 0; i < 11; i++) begin
      for (int k = 0; k < 4; k++) begin
        apply(int'(vecs[i].s[k]));
        check("len1_out", out1, int'(vecs[i].s[k]));
        check("len1_act", act1, int'(vecs[i].s[k] >= 12'd2048));
        if (k < 3) begin
          check("hold_out", out4, m_out);
          check("hold_act", act4, m_act);
        end
      end
      check($sformatf("win%0d_out", i), out4, int'(vecs[i].sum));
      check($sformatf("win%0d_act", i), act4, int'(vecs[i].act));
      m_out = int'(vecs[i].sum);
      m_act = int'(vecs[i].act);
    end

    // Asynchronous reset between edges clears outputs immediately.
    rst = 1'b1;
    #2;
    check("async_out4", out4, 0);
    check("async_act4", act4, 0);
    check("async_out1", out1, 0);
    #2;
    rst = 1'b0;

    // Mid-window reset discards the partial sum.
    apply(7);
    apply(7);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) apply(1);
    check("midrst_out", out4, 4);
    check("midrst_act", act4, 0);

    // Randomised run against a saturating reference.
    m_acc = 0;
    m_cnt = 0;
    m_out = 4;
    m_act = 0;
    for (int n = 0; n < 1000; n++) begin
      v = ($urandom % 2 == 0) ? int'($urandom_range(0, 1200)) : int'($urandom_range(0, 4095));
      apply(v);
      s = sat12(m_acc, v);
      if (m_cnt == 3) begin
        m_out = s;
        m_act = (s >= 2048) ? 1 : 0;
        m_acc = 0;
        m_cnt = 0;
      end else begin
        m_acc = s;
        m_cnt++;
      end
      check("rand_out4", out4, m_out);
      check("rand_act4", act4, m_act);
      check("rand_out1", out1, v);
      check("rand_act1", act1, (v >= 2048) ? 1 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
